// File: rtl/ddr_fifo_loop_pkg.sv
// rtl/ddr_fifo_loop_pkg.sv - shared state encoding and pattern-length helper for the FIFO loop sequencer
package ddr_fifo_loop_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_FILL,
    S_PLAY,
    S_DONE
  } state_t;

  localparam int LEN_MAX_W = 16;

  // Pointers wrap modulo 2**aw, so stop<start still yields a valid length; start==stop means one entry.
  function automatic logic [LEN_MAX_W:0] calc_len(
    input logic [LEN_MAX_W-1:0] start,
    input logic [LEN_MAX_W-1:0] stop,
    input int                   aw
  );
    logic [LEN_MAX_W-1:0] mask;
    mask = LEN_MAX_W'((32'd1 << aw) - 32'd1);
    return {1'b0, (stop - start) & mask} + (LEN_MAX_W+1)'(1);
  endfunction

endpackage

// File: rtl/ddr_loop_idx_cnt.sv
// rtl/ddr_loop_idx_cnt.sv - wrapping pattern index counter with end-of-pattern wrap pulse
module ddr_loop_idx_cnt #(
  parameter int AWIDTH = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [AWIDTH:0]   i_len,
  output logic [AWIDTH-1:0] o_idx,
  output logic              o_wrap
);

  logic [AWIDTH-1:0] r_idx;
  logic              w_last;

  assign w_last = ({1'b0, r_idx} == (i_len - (AWIDTH+1)'(1)));
  assign o_wrap = i_inc & w_last;
  assign o_idx  = r_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= w_last ? '0 : r_idx + AWIDTH'(1);
    end
  end

endmodule

// File: rtl/ddr_fifo_loop_ctrl.sv
// rtl/ddr_fifo_loop_ctrl.sv - clear/load/fill/replay sequencer driving a loop-mode ddr_fifo
module ddr_fifo_loop_ctrl
  import ddr_fifo_loop_pkg::*;
#(
  parameter int AWIDTH  = 3,
  parameter int LCWIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [AWIDTH-1:0]  i_start_ptr,
  input  logic [AWIDTH-1:0]  i_stop_ptr,
  input  logic [LCWIDTH-1:0] i_loop_cnt,
  input  logic               i_pat_wr,
  input  logic               i_rd_ready,
  output logic               o_fifo_clr,
  output logic               o_fifo_load_ptr,
  output logic               o_fifo_loop_mode,
  output logic [AWIDTH-1:0]  o_fifo_start_ptr,
  output logic [AWIDTH-1:0]  o_fifo_stop_ptr,
  output logic               o_fifo_write,
  output logic               o_fifo_read,
  output logic               o_fill_done,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_aborted,
  output logic [LCWIDTH-1:0] o_loops_left
);

  state_t               r_state;
  logic [AWIDTH-1:0]    r_start_ptr;
  logic [AWIDTH-1:0]    r_stop_ptr;
  logic [LCWIDTH-1:0]   r_loops_left;
  logic                 r_fifo_clr;
  logic                 r_load_ptr;
  logic                 r_loop_mode;
  logic                 r_fill_done;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_aborted;

  logic [AWIDTH:0]      w_len;
  logic                 w_abort;
  logic                 w_idx_clr;
  logic                 w_wr_wrap;
  logic                 w_rd_wrap;
  logic [AWIDTH-1:0]    w_wr_idx;
  logic [AWIDTH-1:0]    w_rd_idx;

  assign w_len     = (AWIDTH+1)'(calc_len(LEN_MAX_W'(r_start_ptr), LEN_MAX_W'(r_stop_ptr), AWIDTH));
  assign w_abort   = i_abort & (r_state != S_IDLE);
  assign w_idx_clr = (r_state == S_CLR) | w_abort;

  // Abort also masks the strobes so a cancelled run never touches the FIFO on its last cycle.
  assign o_fifo_write = (r_state == S_FILL) & i_pat_wr & ~i_abort;
  assign o_fifo_read  = (r_state == S_PLAY) & i_rd_ready & ~i_abort;

  ddr_loop_idx_cnt #(.AWIDTH(AWIDTH)) u_wr_idx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_idx_clr),
    .i_inc   (o_fifo_write),
    .i_len   (w_len),
    .o_idx   (w_wr_idx),
    .o_wrap  (w_wr_wrap)
  );

  ddr_loop_idx_cnt #(.AWIDTH(AWIDTH)) u_rd_idx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_idx_clr),
    .i_inc   (o_fifo_read),
    .i_len   (w_len),
    .o_idx   (w_rd_idx),
    .o_wrap  (w_rd_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_start_ptr  <= '0;
      r_stop_ptr   <= '0;
      r_loops_left <= '0;
      r_fifo_clr   <= 1'b0;
      r_load_ptr   <= 1'b0;
      r_loop_mode  <= 1'b0;
      r_fill_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_fifo_clr <= 1'b0;
      r_load_ptr <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      if (w_abort) begin
        r_state      <= S_IDLE;
        r_fifo_clr   <= 1'b1;
        r_aborted    <= 1'b1;
        r_loop_mode  <= 1'b0;
        r_fill_done  <= 1'b0;
        r_busy       <= 1'b0;
        r_loops_left <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state      <= S_CLR;
              r_start_ptr  <= i_start_ptr;
              r_stop_ptr   <= i_stop_ptr;
              r_loops_left <= i_loop_cnt;
              r_fifo_clr   <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
          S_CLR: begin
            r_state     <= S_LOAD;
            r_load_ptr  <= 1'b1;
            r_loop_mode <= 1'b1;
          end
          S_LOAD: r_state <= S_FILL;
          S_FILL: begin
            if (w_wr_wrap) begin
              r_state     <= S_PLAY;
              r_fill_done <= 1'b1;
            end
          end
          S_PLAY: begin
            // A zero loop count never decrements, which is what makes the infinite run stay in PLAY.
            if (w_rd_wrap && (r_loops_left != '0)) begin
              r_loops_left <= r_loops_left - LCWIDTH'(1);
              if (r_loops_left == LCWIDTH'(1)) begin
                r_state     <= S_DONE;
                r_done      <= 1'b1;
                r_loop_mode <= 1'b0;
              end
            end
          end
          S_DONE: begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_fill_done <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_fifo_clr       = r_fifo_clr;
  assign o_fifo_load_ptr  = r_load_ptr;
  assign o_fifo_loop_mode = r_loop_mode;
  assign o_fifo_start_ptr = r_start_ptr;
  assign o_fifo_stop_ptr  = r_stop_ptr;
  assign o_fill_done      = r_fill_done;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_aborted        = r_aborted;
  assign o_loops_left     = r_loops_left;

endmodule

// File: tb/tb_ddr_fifo_loop_ctrl.sv
// tb/tb_ddr_fifo_loop_ctrl.sv - scoreboard bench for the FIFO loop sequencer
module tb_ddr_fifo_loop_ctrl;

  localparam int AW = 3;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0, i_abort = 1'b0, i_pat_wr = 1'b0, i_rd_ready = 1'b0;
  logic [AW-1:0] i_start_ptr = '0, i_stop_ptr = '0;
  logic [LW-1:0] i_loop_cnt = '0;
  logic          o_fifo_clr, o_fifo_load_ptr, o_fifo_loop_mode, o_fifo_write, o_fifo_read;
  logic [AW-1:0] o_fifo_start_ptr, o_fifo_stop_ptr;
  logic          o_fill_done, o_busy, o_done, o_aborted;
  logic [LW-1:0] o_loops_left;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, first_wr_cyc = -1, last_rd_cyc = 0;
  int n_rd = 0, n_wr = 0, n_done = 0, n_abort = 0;
  int m_rp = 0, prev_loops = 0;
  int exp_q[$];
  int loops_q[$];

  ddr_fifo_loop_ctrl #(.AWIDTH(AW), .LCWIDTH(LW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_start_ptr      (i_start_ptr),
    .i_stop_ptr       (i_stop_ptr),
    .i_loop_cnt       (i_loop_cnt),
    .i_pat_wr         (i_pat_wr),
    .i_rd_ready       (i_rd_ready),
    .o_fifo_clr       (o_fifo_clr),
    .o_fifo_load_ptr  (o_fifo_load_ptr),
    .o_fifo_loop_mode (o_fifo_loop_mode),
    .o_fifo_start_ptr (o_fifo_start_ptr),
    .o_fifo_stop_ptr  (o_fifo_stop_ptr),
    .o_fifo_write     (o_fifo_write),
    .o_fifo_read      (o_fifo_read),
    .o_fill_done      (o_fill_done),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_aborted        (o_aborted),
    .o_loops_left     (o_loops_left)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor: models the FIFO read pointer from the controller's pointer outputs and scores every read.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_fifo_load_ptr) m_rp = int'(o_fifo_start_ptr);
      if (o_busy) begin
        chk("rd_gate", int'(o_fifo_read & ~i_rd_ready), 0);
        chk("wr_gate", int'(o_fifo_write & ~i_pat_wr), 0);
      end
      if (o_fifo_write) begin
        if (n_wr == 0) first_wr_cyc = cyc;
        n_wr++;
      end
      if (o_fifo_read) begin
        n_rd++;
        last_rd_cyc = cyc;
        if (exp_q.size() == 0) chk("rd_unexpected", m_rp, -1);
        else chk("rd_addr", m_rp, exp_q.pop_front());
        m_rp = (m_rp == int'(o_fifo_stop_ptr)) ? int'(o_fifo_start_ptr) : (m_rp + 1) % (1 << AW);
      end
      if (o_done) begin
        n_done++;
        chk("done_latency", cyc - last_rd_cyc, 1);
      end
      if (o_aborted) n_abort++;
      if (int'(o_loops_left) != prev_loops) begin
        if (loops_q.size() == 0) chk("loops_unexpected", int'(o_loops_left), prev_loops);
        else chk("loops_seq", int'(o_loops_left), loops_q.pop_front());
      end
    end
    prev_loops = int'(o_loops_left);
  end

  task automatic start_run(input int s, input int e, input int cnt, input int strobes);
    int len;
    len = ((e - s) & ((1 << AW) - 1)) + 1;
    n_rd = 0; n_wr = 0; n_done = 0; n_abort = 0; first_wr_cyc = -1;
    for (int l = 0; l < cnt; l++)
      for (int k = 0; k < len; k++) exp_q.push_back((s + k) % (1 << AW));
    if (cnt > 0)
      for (int l = cnt; l >= 0; l--) loops_q.push_back(l);
    @(posedge clk); #1;
    i_start = 1'b1; i_start_ptr = AW'(s); i_stop_ptr = AW'(e); i_loop_cnt = LW'(cnt);
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0; i_pat_wr = 1'b1;
    repeat (strobes + 2) @(posedge clk);
    #1 i_pat_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit toggle);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (toggle) i_rd_ready = ~i_rd_ready;
      if (!o_busy) break;
    end
    chk("idle_wait_in_budget", int'(k < budget), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_clr", int'(o_fifo_clr), 0);
    chk("rst_loop_mode", int'(o_fifo_loop_mode), 0);
    chk("rst_loops", int'(o_loops_left), 0);
    chk("rst_done", int'(o_done), 0);
    rst_n = 1'b1;

    // basic: 2..5, three loops, continuous ready
    i_rd_ready = 1'b1;
    start_run(2, 5, 3, 4);
    chk("basic_wr_latency", first_wr_cyc - start_cyc, 3);
    wait_idle(100, 1'b0);
    chk("basic_writes", n_wr, 4);
    chk("basic_reads", n_rd, 12);
    chk("basic_done", n_done, 1);
    chk("basic_abort", n_abort, 0);
    chk("basic_expq", exp_q.size(), 0);
    chk("basic_loopsq", loops_q.size(), 0);
    chk("basic_fill_done_idle", int'(o_fill_done), 0);

    // wrap: 6..1 gives len 4, extra strobes must be dropped
    i_rd_ready = 1'b0;
    start_run(6, 1, 1, 6);
    chk("wrap_writes", n_wr, 4);
    chk("wrap_fill_done", int'(o_fill_done), 1);
    chk("wrap_stop_ptr", int'(o_fifo_stop_ptr), 1);
    i_rd_ready = 1'b1;
    wait_idle(100, 1'b0);
    chk("wrap_reads", n_rd, 4);
    chk("wrap_done", n_done, 1);
    chk("wrap_expq", exp_q.size(), 0);

    // backpressure: toggling ready, len 2, two loops
    start_run(3, 4, 2, 2);
    wait_idle(100, 1'b1);
    chk("bp_reads", n_rd, 4);
    chk("bp_done", n_done, 1);
    chk("bp_expq", exp_q.size(), 0);
    chk("bp_loopsq", loops_q.size(), 0);

    // infinite: len 1, loop count 0, then abort
    i_rd_ready = 1'b1;
    for (int k = 0; k < 120; k++) exp_q.push_back(5);
    start_run(5, 5, 0, 1);
    repeat (100) @(posedge clk);
    #1;
    chk("inf_no_done", n_done, 0);
    chk("inf_loops", int'(o_loops_left), 0);
    chk("inf_busy", int'(o_busy), 1);
    chk("inf_many_reads", int'(n_rd >= 90), 1);
    i_abort = 1'b1;
    @(negedge clk);
    chk("inf_abort_rd_gate", int'(o_fifo_read), 0);
    @(posedge clk); #1;
    i_abort = 1'b0;
    chk("inf_aborted", int'(o_aborted), 1);
    chk("inf_abort_clr", int'(o_fifo_clr), 1);
    chk("inf_abort_busy", int'(o_busy), 0);
    chk("inf_abort_loop_mode", int'(o_fifo_loop_mode), 0);
    @(posedge clk); #1;
    chk("inf_aborted_pulse", int'(o_aborted), 0);
    chk("inf_clr_pulse", int'(o_fifo_clr), 0);
    exp_q.delete();

    // simultaneous: start while busy ignored, abort on final read wins
    i_rd_ready = 1'b0;
    start_run(0, 1, 1, 2);
    @(posedge clk); #1;
    i_start = 1'b1; i_start_ptr = 3'd4; i_stop_ptr = 3'd6; i_loop_cnt = 8'd9;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("sim_start_ptr", int'(o_fifo_start_ptr), 0);
    chk("sim_stop_ptr", int'(o_fifo_stop_ptr), 1);
    chk("sim_loops", int'(o_loops_left), 1);
    i_rd_ready = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0; i_rd_ready = 1'b0;
    chk("sim_aborted", int'(o_aborted), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("sim_no_done", n_done, 0);
    chk("sim_reads", n_rd, 1);
    chk("sim_abort_count", n_abort, 1);
    chk("sim_loopsq", loops_q.size(), 0);
    exp_q.delete();

    // async reset in PLAY, then a fresh run
    start_run(2, 3, 2, 2);
    @(posedge clk); #1 i_rd_ready = 1'b1;
    @(posedge clk); #1 i_rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_read", int'(o_fifo_read), 0);
    chk("arst_loops", int'(o_loops_left), 0);
    chk("arst_fill_done", int'(o_fill_done), 0);
    chk("arst_start_ptr", int'(o_fifo_start_ptr), 0);
    chk("arst_loop_mode", int'(o_fifo_loop_mode), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    exp_q.delete();
    loops_q.delete();
    i_rd_ready = 1'b1;
    start_run(1, 2, 1, 2);
    wait_idle(100, 1'b0);
    chk("post_rst_reads", n_rd, 2);
    chk("post_rst_done", n_done, 1);
    chk("post_rst_expq", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
